// File: rtl/axis_bram_pkg.sv
// axis_bram_pkg: shared FSM encoding, latency default and configuration check for the BRAM stream reader
package axis_bram_pkg;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

    localparam int RD_LAT_DEF = 2;

    function automatic bit cfg_ok(input int depth, input int rd_lat);
        return depth >= rd_lat + 2 && (depth & (depth - 1)) == 0 && rd_lat >= 1 && rd_lat <= 2;
    endfunction

endpackage

// File: rtl/axis_bram_reader_if.sv
// axis_bram_reader_if: AXI4-Stream beat channel between the BRAM reader and its consumer
interface axis_bram_reader_if #(
    parameter int DATA_W = 16
);

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);

endinterface

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: first-word-fall-through synchronous FIFO with occupancy count
module axis_sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   push,
    input  logic [DATA_W-1:0]      din,
    input  logic                   pop,
    output logic [DATA_W-1:0]      dout,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Empty reads as zero so stale entries never leak out after a flush
    assign dout = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/axis_bram_reader.sv
// axis_bram_reader: streams a contiguous BRAM region out over AXI4-Stream,
// absorbing read latency and backpressure in a small credit-controlled FIFO.
module axis_bram_reader
    import axis_bram_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int RD_LAT     = RD_LAT_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_addr,
    input  logic [15:0]        count_limit,
    output logic               busy,
    output logic               done,
    output logic               bram_en,
    output logic [ADDR_W-1:0]  bram_addr,
    input  logic [DATA_W-1:0]  bram_dout,
    axis_bram_reader_if.master m_axis
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t            state, state_n;
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       issue_left, beat_left, beat_left_n;
    logic [RD_LAT-1:0] pipe;
    logic [CW-1:0]     inflight, fifo_count;
    logic              hs, push, credit;

    if (!cfg_ok(FIFO_DEPTH, RD_LAT)) begin : g_bad_cfg
        $error("axis_bram_reader: FIFO_DEPTH must be a power of two >= RD_LAT+2 and RD_LAT must be 1 or 2");
    end

    // Credit ignores this cycle's pop, so DEPTH >= RD_LAT+2 keeps one read per cycle
    assign credit      = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH);
    assign push        = pipe[RD_LAT-1];
    assign hs          = m_axis.tvalid && m_axis.tready;
    assign beat_left_n = beat_left - 16'(hs);
    assign bram_addr   = rd_addr;

    assign m_axis.tvalid = fifo_count != '0;
    assign m_axis.tlast  = m_axis.tvalid && beat_left == 16'd1;

    always_ff @(posedge aclk) begin
        state <= !aresetn ? IDLE : state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:   if (start) state_n = (count_limit == '0) ? FINISH : READ;
            READ:   if (bram_en && issue_left == 16'd1) state_n = DRAIN;
            DRAIN:  if (beat_left_n == '0) state_n = FINISH;
            FINISH: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy    = state == READ || state == DRAIN;
        done    = state == FINISH;
        bram_en = state == READ && credit;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_addr    <= '0;
            issue_left <= '0;
            beat_left  <= '0;
            pipe       <= '0;
            inflight   <= '0;
        end else begin
            pipe     <= RD_LAT'({pipe, bram_en});
            inflight <= inflight + CW'(bram_en) - CW'(push);
            if (state == IDLE && start) begin
                rd_addr    <= start_addr;
                issue_left <= count_limit;
                beat_left  <= count_limit;
            end else begin
                if (bram_en) begin
                    rd_addr    <= rd_addr + ADDR_W'(1);
                    issue_left <= issue_left - 16'd1;
                end
                beat_left <= beat_left_n;
            end
        end
    end

    axis_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push    (push),
        .din     (bram_dout),
        .pop     (hs),
        .dout    (m_axis.tdata),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_axis_bram_reader.sv
// tb_axis_bram_reader: randomized and directed checks of the BRAM stream reader against a queue model
module tb_axis_bram_reader;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] start_addr = '0;
    logic [15:0] count_limit = '0;
    logic        busy, done, bram_en;
    logic [15:0] bram_addr, bram_dout;

    logic        b_start = 1'b0;
    logic [15:0] b_addr = '0;
    logic [15:0] b_cnt = '0;
    logic        b_busy, b_done, b_en;
    logic [15:0] b_baddr, b_dout;

    axis_bram_reader_if #(.DATA_W(16)) m_axis ();
    axis_bram_reader_if #(.DATA_W(16)) b_axis ();

    always #5 aclk = ~aclk;

    axis_bram_reader #(.DATA_W(16), .ADDR_W(16), .RD_LAT(2), .FIFO_DEPTH(4)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .start_addr(start_addr),
        .count_limit(count_limit), .busy(busy), .done(done), .bram_en(bram_en),
        .bram_addr(bram_addr), .bram_dout(bram_dout), .m_axis(m_axis.master)
    );

    axis_bram_reader #(.DATA_W(16), .ADDR_W(16), .RD_LAT(1), .FIFO_DEPTH(4)) dut_lat1 (
        .aclk(aclk), .aresetn(aresetn), .start(b_start), .start_addr(b_addr),
        .count_limit(b_cnt), .busy(b_busy), .done(b_done), .bram_en(b_en),
        .bram_addr(b_baddr), .bram_dout(b_dout), .m_axis(b_axis.master)
    );

    // BRAM holds mem[i] = i; reads without a matching enable return a poison value
    logic        e1 = 1'b0, e2 = 1'b0, be1 = 1'b0;
    logic [15:0] a1 = '0, a2 = '0, ba1 = '0;
    always @(posedge aclk) begin
        e1 <= bram_en; a1 <= bram_addr; e2 <= e1; a2 <= a1;
        be1 <= b_en; ba1 <= b_baddr;
    end
    assign bram_dout = e2 ? a2 : 16'hDEAD;
    assign b_dout    = be1 ? ba1 : 16'hDEAD;

    int          errors = 0, checks = 0, cyc = 0;
    logic [15:0] q[$];
    logic [15:0] addr_log[$];
    bit          m_busy = 0, m_done = 0, m_active = 0, prev_rst = 1, prev_stall = 0, rnd = 0;
    logic [15:0] m_addr = '0, first_data = '0, last_data = '0;
    int          m_issue_left = 0, m_iss = 0, m_pop = 0, beats = 0, tlast_cnt = 0, done_cnt = 0;
    int          start_cyc = 0, first_valid_cyc = -1, last_hs_cyc = 0, done_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge aclk) begin
        bit hs, nb, nd;
        cyc++;
        if (prev_rst)
            chk("reset_vals", {busy, done, bram_en, bram_addr, m_axis.tvalid, m_axis.tlast, m_axis.tdata}, 64'd0);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        nb = m_busy;
        nd = 0;
        if (bram_en === 1'b1) begin
            chk("en_allowed", m_issue_left > 0, 1);
            chk("bram_addr", bram_addr, m_addr);
            chk("credit", (m_iss - m_pop) < 4, 1);
            addr_log.push_back(bram_addr);
            m_addr++;
            m_issue_left--;
            m_iss++;
        end
        hs = m_axis.tvalid === 1'b1 && m_axis.tready === 1'b1;
        if (prev_stall) chk("hold_valid", m_axis.tvalid, 1);
        if (m_axis.tvalid === 1'b1) begin
            if (q.size() == 0) chk("spurious_valid", m_axis.tvalid, 0);
            else begin
                chk("tdata", m_axis.tdata, q[0]);
                chk("tlast", m_axis.tlast, q.size() == 1);
            end
            if (first_valid_cyc < 0) begin
                first_valid_cyc = cyc;
                first_data = m_axis.tdata;
            end
        end else chk("tlast_idle", m_axis.tlast, 0);
        if (hs && q.size() > 0) begin
            if (m_axis.tlast === 1'b1) begin
                tlast_cnt++;
                last_data = m_axis.tdata;
            end
            q.delete(0);
            m_pop++;
            beats++;
            last_hs_cyc = cyc;
            if (q.size() == 0) begin
                nb = 0;
                nd = 1;
            end
        end
        prev_stall = m_axis.tvalid === 1'b1 && m_axis.tready !== 1'b1;
        if (start && !m_active && aresetn) begin
            m_active = 1;
            start_cyc = cyc;
            first_valid_cyc = -1;
            addr_log.delete();
            beats = 0;
            tlast_cnt = 0;
            m_iss = 0;
            m_pop = 0;
            m_addr = start_addr;
            m_issue_left = count_limit;
            if (count_limit == 0) nd = 1;
            else begin
                nb = 1;
                for (int i = 0; i < count_limit; i++) q.push_back(start_addr + 16'(i));
            end
        end
        if (m_done) m_active = 0;
        m_busy = nb;
        m_done = nd;
        if (!aresetn) begin
            q.delete();
            m_busy = 0;
            m_done = 0;
            m_active = 0;
            m_issue_left = 0;
            prev_stall = 0;
        end
        prev_rst = !aresetn;
    end

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] addr, input logic [15:0] cnt);
        start = 1'b1;
        start_addr = addr;
        count_limit = cnt;
        tick;
        start = 1'b0;
    endtask

    task automatic run_idle(input int max);
        for (int i = 0; i < max; i++) begin
            tick;
            if (!m_active) break;
            if (rnd) m_axis.tready = 1'($urandom_range(0, 1));
        end
        m_axis.tready = 1'b1;
        chk("idle_timeout", m_active, 0);
    endtask

    logic [15:0] ra;
    int          rn, d0;

    initial begin
        m_axis.tready = 1'b1;
        b_axis.tready = 1'b1;
        repeat (3) tick;
        aresetn = 1'b1;
        tick;

        rnd = 0;
        do_start(16'd256, 16'd128);
        run_idle(400);
        chk("basic_beats", beats, 128);
        chk("basic_first_lat", first_valid_cyc - start_cyc, 4);
        chk("basic_first_data", first_data, 16'd256);
        chk("basic_last_data", last_data, 16'd383);
        chk("basic_tlast_cnt", tlast_cnt, 1);
        chk("basic_no_bubble", last_hs_cyc - first_valid_cyc, 127);
        chk("basic_done_lat", done_cyc - last_hs_cyc, 1);

        rnd = 1;
        do_start(16'd256, 16'd128);
        run_idle(3000);
        chk("bp_beats", beats, 128);
        chk("bp_last_data", last_data, 16'd383);
        chk("bp_tlast_cnt", tlast_cnt, 1);

        rnd = 0;
        do_start(16'h1234, 16'd0);
        run_idle(20);
        chk("zero_done_lat", done_cyc - start_cyc, 1);
        chk("zero_beats", beats, 0);
        chk("zero_reads", m_iss, 0);

        do_start(16'hFFFE, 16'd4);
        run_idle(50);
        chk("wrap_nreads", addr_log.size(), 4);
        if (addr_log.size() == 4) begin
            chk("wrap_a0", addr_log[0], 16'hFFFE);
            chk("wrap_a1", addr_log[1], 16'hFFFF);
            chk("wrap_a2", addr_log[2], 16'h0000);
            chk("wrap_a3", addr_log[3], 16'h0001);
        end
        chk("wrap_beats", beats, 4);
        chk("wrap_last_data", last_data, 16'h0001);

        do_start(16'h1000, 16'd64);
        for (int i = 0; i < 200 && beats < 10; i++) tick;
        chk("rst_reached", beats >= 10, 1);
        d0 = done_cnt;
        aresetn = 1'b0;
        tick;
        aresetn = 1'b1;
        repeat (5) tick;
        chk("rst_no_done", done_cnt, d0);
        chk("rst_busy", busy, 0);
        rnd = 1;
        do_start(16'h0000, 16'd8);
        chk("restart_busy", busy, 1);
        start = 1'b1;
        start_addr = 16'h5555;
        count_limit = 16'd3;
        tick;
        start = 1'b0;
        run_idle(300);
        chk("restart_beats", beats, 8);
        chk("restart_last", last_data, 16'd7);
        chk("restart_tlast_cnt", tlast_cnt, 1);

        for (int k = 0; k < 5; k++) begin
            ra = 16'($urandom);
            rn = $urandom_range(1, 40);
            do_start(ra, 16'(rn));
            run_idle(1000);
            chk("rand_beats", beats, rn);
            chk("rand_last", last_data, ra + 16'(rn - 1));
        end
        rnd = 0;

        b_start = 1'b1;
        b_addr = 16'h0042;
        b_cnt = 16'd1;
        tick;
        b_start = 1'b0;
        chk("l1_busy", b_busy, 1);
        chk("l1_en", b_en, 1);
        chk("l1_addr", b_baddr, 16'h0042);
        tick;
        chk("l1_valid_t2", b_axis.tvalid, 0);
        tick;
        chk("l1_valid_t3", b_axis.tvalid, 1);
        chk("l1_tlast", b_axis.tlast, 1);
        chk("l1_tdata", b_axis.tdata, 16'h0042);
        tick;
        chk("l1_done", b_done, 1);
        chk("l1_busy_off", b_busy, 0);
        chk("l1_valid_off", b_axis.tvalid, 0);
        tick;
        chk("l1_done_pulse", b_done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
